dealer_turn_executor: RTL and testbench

- Executes a blackjack hand turn on behalf of the player-side decision logic (dealer AI or player buttons).
- Deals the opening cards, then raises turnIndicator and waits for a gameCommand.
- On COMMAND_HIT it fetches a card from the deck block over a req/valid handshake and adds it, with soft-ace handling. It ends the turn on COMMAND_STAND, bust, or the card limit.
- Sits between the deck/shuffler and the decision block; feeds handValue back to the decision block.

---
 rtl/dealer_turn_executor_pkg.sv | 21 ++
 rtl/dealer_turn_executor_card_value_decode.sv | 24 ++
 rtl/dealer_turn_executor.sv | 128 ++++++++++++
 tb/tb_dealer_turn_executor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dealer_turn_executor_pkg.sv
// Shared blackjack types and constants for the dealer/player hand logic.
package dealer_turn_executor_pkg;

  typedef logic [4:0] hand;

  typedef enum logic [1:0] {
    COMMAND_NONE  = 2'd0,
    COMMAND_HIT   = 2'd1,
    COMMAND_STAND = 2'd2
  } gameCommand;

  localparam logic [5:0] BUST_LIMIT     = 6'd21;
  localparam logic [5:0] ACE_SOFT_DELTA = 6'd10;

  localparam logic [3:0] RANK_ACE   = 4'd1;
  localparam logic [3:0] RANK_TEN   = 4'd10;
  localparam logic [3:0] RANK_JACK  = 4'd11;
  localparam logic [3:0] RANK_KING  = 4'd13;
  localparam logic [3:0] ACE_HIGH   = 4'd11;

endpackage

// File: rtl/dealer_turn_executor_card_value_decode.sv
// Maps a deck rank to its blackjack point value; aces decode high (11).
module card_value_decode
  import dealer_turn_executor_pkg::*;
(
  input  logic [3:0] rank,
  output logic [3:0] value,
  output logic       is_ace,
  output logic       rank_valid
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    value      = rank;
    is_ace     = 1'b0;
    rank_valid = (rank >= RANK_ACE) && (rank <= RANK_KING);
    if (rank == RANK_ACE) begin
      value  = ACE_HIGH;
      is_ace = 1'b1;
    end else if (rank >= RANK_JACK) begin
      value = RANK_TEN;
    end
  end

endmodule

// File: rtl/dealer_turn_executor.sv
// Runs one blackjack hand: deals opening cards, then hits/stands on command
// until stand, bust or the card limit ends the turn.
module dealer_turn_executor
  import dealer_turn_executor_pkg::*;
#(
  parameter int INIT_CARDS = 2,
  parameter int MAX_CARDS  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  gameCommand command,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_rank,
  output logic       turnIndicator,
  output hand        handValue,
  output logic [3:0] card_count,
  output logic       busted,
  output logic       stood,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEAL,
    S_DECIDE,
    S_REQUEST,
    S_DONE
  } state_t;

  localparam logic [3:0] INIT_C = 4'(INIT_CARDS);
  localparam logic [3:0] MAX_C  = 4'(MAX_CARDS);

  state_t     state;
  logic [3:0] soft_aces;

  logic [3:0] card_value;
  logic       card_is_ace;
  logic       card_ok;
  logic       accept;
  logic [3:0] aces_inc;
  logic [5:0] tentative;
  logic [5:0] sum_next;
  logic [3:0] aces_next;
  logic [3:0] count_next;

  card_value_decode u_decode (
    .rank       (card_rank),
    .value      (card_value),
    .is_ace     (card_is_ace),
    .rank_valid (card_ok)
  );

  assign card_req      = (state == S_DEAL) || (state == S_REQUEST);
  assign turnIndicator = (state == S_DECIDE);
  assign done          = (state == S_DONE);

  assign accept     = card_req && card_valid && card_ok;
  assign aces_inc   = soft_aces + 4'(card_is_ace);
  assign tentative  = {1'b0, handValue} + {2'b00, card_value};
  assign count_next = card_count + 4'd1;

  // A soft ace (counted as 11) may be demoted to 1 once per incoming card.
  always_comb begin
    sum_next  = tentative;
    aces_next = aces_inc;
    if ((tentative > BUST_LIMIT) && (aces_inc != 4'd0)) begin
      sum_next  = tentative - ACE_SOFT_DELTA;
      aces_next = aces_inc - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      handValue  <= '0;
      card_count <= '0;
      soft_aces  <= '0;
      busted     <= 1'b0;
      stood      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            handValue  <= '0;
            card_count <= '0;
            soft_aces  <= '0;
            busted     <= 1'b0;
            stood      <= 1'b0;
            state      <= S_DEAL;
          end
        end
        S_DEAL, S_REQUEST: begin
          if (accept) begin
            handValue  <= sum_next[4:0];
            soft_aces  <= aces_next;
            card_count <= count_next;
            if (sum_next > BUST_LIMIT) begin
              busted <= 1'b1;
              state  <= S_DONE;
            end else if (count_next == MAX_C) begin
              stood <= 1'b1;
              state <= S_DONE;
            end else if ((state == S_DEAL) && (count_next < INIT_C)) begin
              state <= S_DEAL;
            end else begin
              state <= S_DECIDE;
            end
          end
        end
        S_DECIDE: begin
          case (command)
            COMMAND_HIT:   state <= S_REQUEST;
            COMMAND_STAND: begin
              stood <= 1'b1;
              state <= S_DONE;
            end
            default: ;
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dealer_turn_executor.sv
// Drives directed and random hands into dealer_turn_executor and compares
// every output each cycle against a rule-level model of the hand.
module tb_dealer_turn_executor;
  import dealer_turn_executor_pkg::*;

  localparam int INIT_N = 2;
  localparam int MAX_N  = 4;

  typedef enum {PH_IDLE, PH_DEAL, PH_DECIDE, PH_REQ, PH_DONE} phase_t;

  logic       clk;
  logic       reset;
  logic       start;
  gameCommand command;
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_rank;
  logic       turnIndicator;
  hand        handValue;
  logic [3:0] card_count;
  logic       busted;
  logic       stood;
  logic       done;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;

  phase_t m_phase  = PH_IDLE;
  int     m_total  = 0;
  int     m_soft   = 0;
  int     m_count  = 0;
  bit     m_busted = 0;
  bit     m_stood  = 0;

  dealer_turn_executor #(
    .INIT_CARDS (INIT_N),
    .MAX_CARDS  (MAX_N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .command       (command),
    .card_req      (card_req),
    .card_valid    (card_valid),
    .card_rank     (card_rank),
    .turnIndicator (turnIndicator),
    .handValue     (handValue),
    .card_count    (card_count),
    .busted        (busted),
    .stood         (stood),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Blackjack rules: ace counts 11, faces 10; one soft-ace demotion per card.
  task automatic model_card(input int rank);
    int val;
    int t;
    val = (rank == 1) ? 11 : (rank >= 11) ? 10 : rank;
    if (rank == 1) m_soft++;
    t = m_total + val;
    if (t > 21 && m_soft > 0) begin
      t = t - 10;
      m_soft--;
    end
    m_total = t;
    m_count++;
    if (m_total > 21) begin
      m_busted = 1;
      m_phase  = PH_DONE;
    end else if (m_count == MAX_N) begin
      m_stood = 1;
      m_phase = PH_DONE;
    end else if (m_phase == PH_DEAL && m_count < INIT_N) begin
      m_phase = PH_DEAL;
    end else begin
      m_phase = PH_DECIDE;
    end
  endtask

  task automatic model_clear();
    m_total  = 0;
    m_soft   = 0;
    m_count  = 0;
    m_busted = 0;
    m_stood  = 0;
  endtask

  task automatic model_edge(input bit st, input gameCommand cmd, input bit v,
                            input logic [3:0] r, input bit rst);
    if (rst) begin
      model_clear();
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE, PH_DONE: if (st) begin
          model_clear();
          m_phase = PH_DEAL;
        end
        PH_DEAL, PH_REQ: if (v && r >= 1 && r <= 13) model_card(int'(r));
        PH_DECIDE: begin
          if (cmd == COMMAND_HIT) m_phase = PH_REQ;
          else if (cmd == COMMAND_STAND) begin
            m_stood = 1;
            m_phase = PH_DONE;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".card_req"}, 8'(card_req), 8'(m_phase == PH_DEAL || m_phase == PH_REQ));
    check({tag, ".turnIndicator"}, 8'(turnIndicator), 8'(m_phase == PH_DECIDE));
    check({tag, ".done"}, 8'(done), 8'(m_phase == PH_DONE));
    check({tag, ".handValue"}, 8'(handValue), 8'(m_total));
    check({tag, ".card_count"}, 8'(card_count), 8'(m_count));
    check({tag, ".busted"}, 8'(busted), 8'(m_busted));
    check({tag, ".stood"}, 8'(stood), 8'(m_stood));
  endtask

  task automatic step(input string tag, input bit st, input gameCommand cmd,
                      input bit v, input logic [3:0] r, input bit rst);
    start      = st;
    command    = cmd;
    card_valid = v;
    card_rank  = r;
    reset      = rst;
    @(posedge clk);
    cyc++;
    model_edge(st, cmd, v, r, rst);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, COMMAND_NONE, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic go(input string tag);
    step(tag, 1'b1, COMMAND_NONE, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic give(input string tag, input logic [3:0] r);
    step(tag, 1'b0, COMMAND_NONE, 1'b1, r, 1'b0);
  endtask

  task automatic cmd(input string tag, input gameCommand c);
    step(tag, 1'b0, c, 1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    start      = 1'b0;
    command    = COMMAND_NONE;
    card_valid = 1'b0;
    card_rank  = 4'd0;
    reset      = 1'b1;

    // Reset with a pending card on the bus.
    step("reset0", 1'b0, COMMAND_NONE, 1'b1, 4'd5, 1'b1);
    step("reset1", 1'b0, COMMAND_NONE, 1'b1, 4'd5, 1'b1);
    idle("idle");

    // 10 + 7 = 17, then stand.
    go("h1_start");
    give("h1_c10", 4'd10);
    give("h1_c7", 4'd7);
    cmd("h1_stand", COMMAND_STAND);
    idle("h1_hold0");
    idle("h1_hold1");

    // A, A, K: 11, 12, then 22 softened back to 12.
    go("h2_start");
    give("h2_ace1", 4'd1);
    give("h2_ace2", 4'd1);
    cmd("h2_hit", COMMAND_HIT);
    give("h2_king", 4'd13);
    cmd("h2_stand", COMMAND_STAND);

    // 10, 6, Q: bust at 26.
    go("h3_start");
    give("h3_c10", 4'd10);
    give("h3_c6", 4'd6);
    cmd("h3_hit", COMMAND_HIT);
    give("h3_queen", 4'd12);
    idle("h3_after");

    // Stalled deck, invalid ranks, then a valid 2; start and illegal command in DECIDE.
    go("h4_start");
    give("h4_c5a", 4'd5);
    give("h4_c5b", 4'd5);
    step("h4_start_in_decide", 1'b1, COMMAND_NONE, 1'b0, 4'd0, 1'b0);
    cmd("h4_illegal_cmd", gameCommand'(2'd3));
    cmd("h4_hit", COMMAND_HIT);
    for (int i = 0; i < 5; i++) idle("h4_stall");
    give("h4_rank0", 4'd0);
    give("h4_rank14", 4'd14);
    give("h4_rank15", 4'd15);
    give("h4_c2", 4'd2);
    cmd("h4_stand", COMMAND_STAND);

    // Card limit: 2,2,2,2 ends the turn without a stand.
    go("h5_start");
    give("h5_c2a", 4'd2);
    give("h5_c2b", 4'd2);
    cmd("h5_hit1", COMMAND_HIT);
    give("h5_c2c", 4'd2);
    cmd("h5_hit2", COMMAND_HIT);
    give("h5_c2d", 4'd2);
    idle("h5_after");

    // Reset while a card is being presented in REQUEST.
    go("h6_start");
    give("h6_c3", 4'd3);
    give("h6_c4", 4'd4);
    cmd("h6_hit", COMMAND_HIT);
    step("h6_reset", 1'b0, COMMAND_NONE, 1'b1, 4'd9, 1'b1);
    idle("h6_idle");

    // Random play, including ignored starts/commands, stalls, bad ranks and resets.
    for (int i = 0; i < 3000; i++) begin
      bit             st;
      bit             v;
      bit             rst;
      logic [3:0]     r;
      gameCommand     c;
      int unsigned    pick;
      rst  = ($urandom_range(0, 299) == 0);
      if (m_phase == PH_IDLE || m_phase == PH_DONE) st = ($urandom_range(0, 1) == 0);
      else st = ($urandom_range(0, 7) == 0);
      c    = gameCommand'(2'($urandom_range(0, 3)));
      v    = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      if (pick == 0) r = 4'd0;
      else if (pick == 1) r = 4'(13 + $urandom_range(1, 2));
      else r = 4'($urandom_range(1, 13));
      step("rand", st, c, v, r, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
